// File: rtl/clock_pkg.sv
// Shared clock-field definitions: operating mode codes used by every field counter.
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN       = 2'd0,
    MODE_SET_SEC   = 2'd1,
    MODE_SET_MIN   = 2'd2,
    MODE_SET_HOURS = 2'd3
  } mode_e;

endpackage

// File: rtl/counter_modn_field.sv
// Modulo-N up/down counter for one clock field (sec/min/hours) with guarded load,
// set-mode single-step adjust, cascade carry and wrap / load-error pulses.
module counter_modn_field
  import clock_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MODULUS   = 24,
  parameter int unsigned MIN_VALUE = 0,
  parameter int unsigned FIELD_ID  = 3
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic             Enable,
  input  logic             Down,
  input  logic             Load,
  input  mode_e            Mode,
  input  logic [WIDTH-1:0] Value,
  input  logic             Adj_Up,
  input  logic             Adj_Dn,
  output logic [WIDTH-1:0] Q,
  output logic             RCO,
  output logic             Wrapped,
  output logic             Load_Err
);

  if ((MODULUS < 2) ||
      ((64'(MIN_VALUE) + 64'(MODULUS) - 64'd1) > ((64'd1 << WIDTH) - 64'd1))) begin : g_param_err
    $error("counter_modn_field: range does not fit WIDTH or MODULUS < 2");
  end

  localparam int unsigned MaxValue = MIN_VALUE + MODULUS - 1;

  localparam logic [WIDTH-1:0] MinQ = WIDTH'(MIN_VALUE);
  localparam logic [WIDTH-1:0] MaxQ = WIDTH'(MaxValue);
  localparam logic [WIDTH-1:0] OneQ = WIDTH'(1);

  // Range and endpoint compares run one bit wider than the count.
  localparam logic [WIDTH:0]   MinW  = (WIDTH+1)'(MIN_VALUE);
  localparam logic [WIDTH:0]   MaxW  = (WIDTH+1)'(MaxValue);
  localparam logic [WIDTH+1:0] SpanW = (WIDTH+2)'(MODULUS - 1);

  localparam logic [1:0] FieldCode = 2'(FIELD_ID);

  // Offset from MIN_VALUE; values below the floor wrap to a huge offset and fail.
  function automatic logic in_range(input logic [WIDTH-1:0] v);
    logic [WIDTH+1:0] off;
    off = {2'b00, v} - {1'b0, MinW};
    return off <= SpanW;
  endfunction

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrapped_q, wrapped_d;
  logic             load_err_q, load_err_d;

  logic [WIDTH:0] q_ext;
  logic           field_sel;
  logic           q_ok;
  logic           at_min;
  logic           at_max;
  logic           adj_one;
  logic           adj_both;

  assign q_ext     = {1'b0, q_q};
  assign field_sel = (Mode == FieldCode);
  assign q_ok      = in_range(q_q);
  assign at_min    = (q_ext == MinW);
  assign at_max    = (q_ext == MaxW);
  assign adj_one   = field_sel && (Adj_Up ^ Adj_Dn);
  assign adj_both  = field_sel && Adj_Up && Adj_Dn;

  always_comb begin
    q_d        = q_q;
    wrapped_d  = 1'b0;
    load_err_d = 1'b0;
    if (field_sel && Load) begin
      if (in_range(Value)) begin
        q_d = Value;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (adj_one) begin
      // Set-mode stepping wraps silently so it never ripples into the next field.
      if (!q_ok) begin
        q_d = MinQ;
      end else if (Adj_Up) begin
        q_d = at_max ? MinQ : q_q + OneQ;
      end else begin
        q_d = at_min ? MaxQ : q_q - OneQ;
      end
    end else if (adj_both) begin
      q_d = q_q;
    end else if (Enable) begin
      if (!q_ok) begin
        q_d = MinQ;
      end else if (!Down) begin
        if (at_max) begin
          q_d       = MinQ;
          wrapped_d = 1'b1;
        end else begin
          q_d = q_q + OneQ;
        end
      end else begin
        if (at_min) begin
          q_d       = MaxQ;
          wrapped_d = 1'b1;
        end else begin
          q_d = q_q - OneQ;
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      q_q        <= MinQ;
      wrapped_q  <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      q_q        <= q_d;
      wrapped_q  <= wrapped_d;
      load_err_q <= load_err_d;
    end
  end

  // Combinational so a cascaded field sees the carry on the same edge.
  always_comb begin
    RCO = Enable && (Down ? at_min : at_max);
  end

  assign Q        = q_q;
  assign Wrapped  = wrapped_q;
  assign Load_Err = load_err_q;

endmodule

// File: tb/tb_counter_modn_field.sv
// Directed bench for counter_modn_field: table of single-edge vectors plus
// hand-written reset, cascade-borrow and offset-range sequences.
module tb_counter_modn_field;
  import clock_pkg::*;

  logic       clk = 1'b0;
  logic       clr;
  logic       enable, down, load, adj_up, adj_dn;
  mode_e      mode;
  logic [7:0] value;
  logic [7:0] q;
  logic       rco, wrapped, load_err;

  logic       enable_b, down_b, load_b, adj_up_b, adj_dn_b;
  mode_e      mode_b;
  logic [3:0] value_b;
  logic [3:0] q_b;
  logic       rco_b, wrapped_b, load_err_b;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  counter_modn_field #(
    .WIDTH(8), .MODULUS(24), .MIN_VALUE(0), .FIELD_ID(3)
  ) dut (
    .Clk(clk), .Clr(clr), .Enable(enable), .Down(down), .Load(load), .Mode(mode),
    .Value(value), .Adj_Up(adj_up), .Adj_Dn(adj_dn), .Q(q), .RCO(rco),
    .Wrapped(wrapped), .Load_Err(load_err)
  );

  counter_modn_field #(
    .WIDTH(4), .MODULUS(12), .MIN_VALUE(1), .FIELD_ID(3)
  ) dut_b (
    .Clk(clk), .Clr(clr), .Enable(enable_b), .Down(down_b), .Load(load_b), .Mode(mode_b),
    .Value(value_b), .Adj_Up(adj_up_b), .Adj_Dn(adj_dn_b), .Q(q_b), .RCO(rco_b),
    .Wrapped(wrapped_b), .Load_Err(load_err_b)
  );

  typedef struct {
    logic       en;
    logic       down;
    logic       load;
    logic [1:0] mode;
    logic [7:0] value;
    logic       up;
    logic       dn;
    logic [7:0] q;
    logic       rco;
    logic       wr;
    logic       le;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic idle_a();
    enable = 1'b0; down = 1'b0; load = 1'b0; mode = MODE_RUN;
    value = 8'd0; adj_up = 1'b0; adj_dn = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            en   dn   ld   mode  value  up   dn    q      rco  wr   le
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 2'd3, 8'd22, 1'b0, 1'b0, 8'd22, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 2'd0, 8'd0,  1'b0, 1'b0, 8'd23, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 2'd0, 8'd0,  1'b0, 1'b0, 8'd0,  1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 2'd0, 8'd0,  1'b0, 1'b0, 8'd0,  1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 2'd3, 8'd30, 1'b0, 1'b0, 8'd0,  1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 2'd3, 8'd15, 1'b0, 1'b0, 8'd15, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 2'd3, 8'd24, 1'b0, 1'b0, 8'd15, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 2'd3, 8'd0,  1'b0, 1'b0, 8'd0,  1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 2'd3, 8'd0,  1'b0, 1'b1, 8'd23, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 2'd3, 8'd0,  1'b1, 1'b0, 8'd0,  1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 2'd3, 8'd0,  1'b1, 1'b1, 8'd0,  1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 2'd3, 8'd5,  1'b0, 1'b0, 8'd5,  1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 2'd0, 8'd9,  1'b0, 1'b0, 8'd6,  1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 2'd1, 8'd0,  1'b1, 1'b0, 8'd6,  1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b1, 1'b0, 2'd1, 8'd0,  1'b0, 1'b1, 8'd5,  1'b0, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 2'd3, 8'd0,  1'b0, 1'b0, 8'd0,  1'b0, 1'b0, 1'b0};
    vecs[16] = '{1'b1, 1'b1, 1'b0, 2'd0, 8'd0,  1'b0, 1'b0, 8'd23, 1'b0, 1'b1, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 1'b0, 2'd0, 8'd0,  1'b0, 1'b0, 8'd0,  1'b0, 1'b1, 1'b0};
    vecs[18] = '{1'b0, 1'b0, 1'b1, 2'd3, 8'd23, 1'b0, 1'b0, 8'd23, 1'b0, 1'b0, 1'b0};
    vecs[19] = '{1'b0, 1'b0, 1'b0, 2'd3, 8'd0,  1'b1, 1'b0, 8'd0,  1'b0, 1'b0, 1'b0};

    idle_a();
    enable_b = 1'b0; down_b = 1'b0; load_b = 1'b0; mode_b = MODE_RUN;
    value_b = 4'd0; adj_up_b = 1'b0; adj_dn_b = 1'b0;
    clr = 1'b0;

    // Reset state, RCO still live while held in reset
    step();
    check("reset q", q, 8'd0);
    check("reset wrapped", wrapped, 1'b0);
    check("reset load_err", load_err, 1'b0);
    check("reset rco idle", rco, 1'b0);
    check("reset q_b", q_b, 4'd1);
    enable = 1'b1; down = 1'b1;
    #1;
    check("reset rco down", rco, 1'b1);
    down = 1'b0;
    #1;
    check("reset rco up", rco, 1'b0);

    @(negedge clk);
    idle_a();
    clr = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      enable = vecs[i].en;
      down   = vecs[i].down;
      load   = vecs[i].load;
      mode   = mode_e'(vecs[i].mode);
      value  = vecs[i].value;
      adj_up = vecs[i].up;
      adj_dn = vecs[i].dn;
      step();
      check($sformatf("vec%0d q", i), q, vecs[i].q);
      check($sformatf("vec%0d rco", i), rco, vecs[i].rco);
      check($sformatf("vec%0d wrapped", i), wrapped, vecs[i].wr);
      check($sformatf("vec%0d load_err", i), load_err, vecs[i].le);
    end

    // Asynchronous clear between edges, then a load discarded under clear
    @(negedge clk);
    idle_a();
    mode = MODE_SET_HOURS; load = 1'b1; value = 8'd17;
    step();
    check("seq load17 q", q, 8'd17);
    @(negedge clk);
    load = 1'b1; value = 8'd30;
    #2;
    clr = 1'b0;
    #1;
    check("seq async clr q", q, 8'd0);
    check("seq async clr load_err", load_err, 1'b0);
    step();
    check("seq clr held q", q, 8'd0);
    check("seq clr held load_err", load_err, 1'b0);
    @(negedge clk);
    idle_a();
    enable = 1'b1;
    clr = 1'b1;
    step();
    check("seq post-release q", q, 8'd1);

    // Offset range instance: borrow from MIN_VALUE wraps to MAX
    @(negedge clk);
    idle_a();
    enable_b = 1'b1; down_b = 1'b1;
    #1;
    check("b rco at min", rco_b, 1'b1);
    step();
    check("b wrap q", q_b, 4'd12);
    check("b wrapped", wrapped_b, 1'b1);
    check("b rco at max down", rco_b, 1'b0);
    @(negedge clk);
    enable_b = 1'b0;
    step();
    check("b wrapped clears", wrapped_b, 1'b0);
    check("b hold q", q_b, 4'd12);
    @(negedge clk);
    mode_b = MODE_SET_HOURS; load_b = 1'b1; value_b = 4'd0;
    step();
    check("b load below min q", q_b, 4'd12);
    check("b load below min err", load_err_b, 1'b1);
    @(negedge clk);
    value_b = 4'd1;
    step();
    check("b load min q", q_b, 4'd1);
    check("b load min err", load_err_b, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
